// File: rtl/schedp.sv
// Instruction phase scheduler: sequences reset, fetch, execute, memory and
// writeback phases, with stall, bypass and halt control, and counts retired
// instructions. The state register advances on the falling edge of clk.
module schedp #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wait_req,
  input  logic             skip_mem,
  input  logic             skip_wb,
  input  logic             halt,
  input  logic             run,
  output logic             phf,
  output logic             phe,
  output logic             phm,
  output logic             phw,
  output logic             phh,
  output logic             retire,
  output logic [CNT_W-1:0] icnt,
  output logic [2:0]       clk_stat
);

  typedef enum logic [2:0] {
    StRst   = 3'b000,
    StRstl  = 3'b001,
    StFetch = 3'b010,
    StExec  = 3'b011,
    StMem   = 3'b100,
    StWb    = 3'b101,
    StHalt  = 3'b110
  } state_e;

  // The reset cycle itself counts as the first RST cycle, so the counter
  // starts at 1 and RST is left once it reaches RESET_CYCLES-1.
  localparam logic [3:0] RstCntStart = 4'd1;
  localparam logic [3:0] RstCntLast  = 4'(RESET_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;

  logic   fin;        // current phase is the last one of the instruction
  state_e end_state;  // where a completing instruction goes

  // Decide whether the current phase completes the instruction.
  always_comb begin
    fin = 1'b0;
    case (state_q)
      StExec:  fin = skip_mem & skip_wb;
      StMem:   fin = skip_wb;
      StWb:    fin = 1'b1;
      default: fin = 1'b0;
    endcase
  end

  // Reset dominates, then the stall; a completion only counts when neither holds.
  always_comb begin
    retire    = fin & ~wait_req & ~reset;
    end_state = halt ? StHalt : StFetch;
  end

  // Next-state, reset-sequence counter and retire counter.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    icnt_d    = icnt_q;
    if (retire) begin
      icnt_d = icnt_q + 1'b1;
    end
    case (state_q)
      StRst: begin
        if (rst_cnt_q >= RstCntLast) begin
          state_d = StRstl;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end
      StRstl: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (!wait_req) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (!wait_req) begin
          if (!skip_mem) begin
            state_d = StMem;
          end else if (!skip_wb) begin
            state_d = StWb;
          end else begin
            state_d = end_state;
          end
        end
      end
      StMem: begin
        if (!wait_req) begin
          state_d = skip_wb ? end_state : StWb;
        end
      end
      StWb: begin
        if (!wait_req) begin
          state_d = end_state;
        end
      end
      StHalt: begin
        if (run) begin
          state_d = StFetch;
        end
      end
      default: begin
        // Unused encoding recovers through a full reset sequence.
        state_d   = StRst;
        rst_cnt_d = RstCntStart;
      end
    endcase
  end

  // State registers with synchronous reset on the falling edge.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q   <= StRst;
      rst_cnt_q <= RstCntStart;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      icnt_q    <= icnt_d;
    end
  end

  // Phase strobes decoded from the state; RSTL presents as a fetch phase.
  always_comb begin
    phf      = (state_q == StFetch) || (state_q == StRstl);
    phe      = (state_q == StExec);
    phm      = (state_q == StMem);
    phw      = (state_q == StWb);
    phh      = (state_q == StHalt);
    icnt     = icnt_q;
    clk_stat = state_q;
  end

endmodule

// File: doc/schedp.md
SCHEDP -- requirements
Module: schedp

Interface
REQ-001 Parameter RESET_CYCLES, default 2, SHALL be the total reset-sequence length in cycles; legal range 2..15.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of the retired-instruction counter; legal range 1..32.
REQ-003 Port clk, input, 1, SHALL be the single clock; the state register updates on the falling edge of clk.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset sampled on the falling edge of clk.
REQ-005 Port wait_req, input, 1, SHALL hold the current execution phase, as a memory/peripheral stall.
REQ-006 Port skip_mem, input, 1, SHALL request bypass of MEM after EXEC.
REQ-007 Port skip_wb, input, 1, SHALL request bypass of WB.
REQ-008 Port halt, input, 1, SHALL request entry to HALT at instruction completion.
REQ-009 Port run, input, 1, SHALL request leaving HALT.
REQ-010 Ports phf, phe, phm, phw, phh, output, 1 each, SHALL be the fetch, exec, mem, writeback and halted phase strobes.
REQ-011 Port retire, output, 1, SHALL flag the completing cycle of an instruction.
REQ-012 Port icnt, output, CNT_W, SHALL be the retired-instruction count.
REQ-013 Port clk_stat, output, 3, SHALL expose the state encoding.

Function
REQ-014 States and clk_stat encodings SHALL be: RST 000, RSTL 001, FETCH 010, EXEC 011, MEM 100, WB 101, HALT 110.
REQ-015 An internal counter SHALL keep the block in RST for RESET_CYCLES-1 cycles after reset deasserts, counting from the reset cycle; RSTL then lasts exactly 1 cycle.
REQ-016 Transitions with wait_req=0 SHALL be:
- RSTL->FETCH
- FETCH->EXEC
- EXEC->MEM if skip_mem=0
- EXEC->WB if skip_mem=1 and skip_wb=0
- EXEC->end if skip_mem=1 and skip_wb=1
- MEM->WB if skip_wb=0
- MEM->end if skip_wb=1
- WB->end
REQ-017 "end" SHALL mean HALT if halt=1, else FETCH; skip_mem, skip_wb and halt are sampled on the same edge that takes the transition.
REQ-018 wait_req=1 SHALL hold FETCH, EXEC, MEM and WB unchanged; wait_req SHALL be ignored in RST, RSTL and HALT.
REQ-019 In HALT, run=1 SHALL move the block to FETCH on the next edge, and halt SHALL be ignored; with run=0 the block stays in HALT.
REQ-020 Phase strobes SHALL decode combinationally from state:
- phf = FETCH or RSTL
- phe = EXEC
- phm = MEM
- phw = WB
- phh = HALT
- At most one strobe is high in any cycle.
REQ-021 retire SHALL be combinational: high in a cycle whose next transition is "end" with wait_req=0, else low.
REQ-022 icnt SHALL increment by 1 on each edge where retire=1, wrapping from 2^CNT_W-1 to 0.
REQ-023 Unused encoding 111 SHALL transition to RST on the next edge.
REQ-024 Priority SHALL be reset > wait_req > skip/halt/run decisions.

Reset
REQ-025 reset=1 on an edge SHALL set state to RST, clk_stat=000, icnt=0, and the RST counter to its start value, regardless of current state.
REQ-026 In the reset cycle, all strobes and retire SHALL be 0.
REQ-027 Reset asserted mid-instruction or during a stall SHALL abandon the instruction without a retire.

Verification
REQ-028 Scenario: RESET_CYCLES=2, reset for 1 edge, then all inputs 0 -> clk_stat sequence 000,001,010,011,100,101,010 with retire high only in the 101 cycle; icnt=1.
REQ-029 Scenario: RESET_CYCLES=4 -> 000 held 3 cycles, then 001 for 1 cycle, then 010.
REQ-030 Scenario: wait_req=1 for 3 cycles during MEM -> phm high 4 cycles, retire 0 throughout MEM, then WB.
REQ-031 Scenario: skip_mem=1, skip_wb=1 in EXEC with halt=1 -> retire=1 in EXEC, next state HALT (110), phh=1; run=1 for 1 cycle -> FETCH.
REQ-032 Scenario: CNT_W=2 with 5 back-to-back instructions -> icnt sequence 1,2,3,0,1.
REQ-033 Scenario: reset asserted during EXEC -> next state RST, icnt=0, no retire pulse.
